// File: rtl/seg_mux_pkg.sv
// Shared types and constants for the multiplexed seven-segment display driver:
// scan-state encoding, the all-off segment pattern and the hex glyph table.
package seg_mux_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Segments are active-low, ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/seven_seg_display.sv
// Hex nibble to active-low seven-segment pattern, {g,f,e,d,c,b,a}.
module seven_seg_display
  import seg_mux_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[hex];

endmodule

// File: rtl/seg_mux_display.sv
// Time-multiplexed common-anode display scanner with dead-time blanking,
// frame-synchronous double-buffered digit updates and leading-zero blanking.
module seg_mux_display
  import seg_mux_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = 48000,
  parameter int BLANK_CYCLES = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  scan_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  digits_t                shadow_q, shadow_d;
  digits_t                pend_q, pend_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [6:0]             seg_q, seg_d;
  logic [NUM_DIGITS-1:0]  anode_q, anode_d;
  logic                   frame_done_q, frame_done_d;

  logic                   frame_boundary;
  logic [NUM_DIGITS-1:0]  lz_suppress;
  logic [3:0]             dec_nibble;
  logic [6:0]             dec_seg;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + 1'b1;
    idx_d          = idx_q;
    frame_boundary = 1'b0;
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          state_d        = ST_BLANK;
          cnt_d          = '0;
          frame_boundary = (idx_q == IDX_LAST);
          idx_d          = frame_boundary ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // New digits only reach the shadow copy at the frame boundary, so one
  // frame never shows a mix of old and new values.
  always_comb begin
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (frame_boundary) begin
      if (load) begin
        shadow_d = digits_in;
      end else if (pend_valid_q) begin
        shadow_d = pend_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_d       = digits_in;
      pend_valid_d = 1'b1;
    end
  end

  // Digit k is a leading zero when it and every more significant digit are 0.
  always_comb begin
    logic upper_zero;
    upper_zero  = 1'b1;
    lz_suppress = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      upper_zero     = upper_zero && (shadow_d[k] == 4'h0);
      lz_suppress[k] = blank_lz && upper_zero;
    end
  end

  assign dec_nibble = shadow_d[idx_d];

  seven_seg_display u_decode (
    .hex (dec_nibble),
    .seg (dec_seg)
  );

  // Outputs are built from the next-state values so the registered pins line
  // up with the scan state during the same cycle.
  always_comb begin
    seg_d   = SEG_OFF;
    anode_d = '1;
    if (state_d == ST_DRIVE && !lz_suppress[idx_d]) begin
      anode_d[idx_d] = 1'b0;
      seg_d          = dec_seg;
    end
    frame_done_d = (state_d == ST_DRIVE) && (cnt_d == DWELL_LAST) && (idx_d == IDX_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      // NOTE: the digit buffers are a handful of flops rather than a RAM, so
      // they are reset; a reset must discard pending data and show zeros.
      shadow_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= SEG_OFF;
      anode_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign anode      = anode_q;
  assign frame_done = frame_done_q;

endmodule
